// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Used by instruction_fetch_unit, fetch_pc_reg and the bench.
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    FS_IDLE = 2'd0,
    FS_WAIT = 2'd1,
    FS_DROP = 2'd2
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] ARM_NOP = 32'hE1A0_0000;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: reset value, load-target,
// load-increment (by one instruction) and hold.
module fetch_pc_reg
  import instruction_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_tgt_i,
  input  logic [ADDR_W-1:0] tgt_i,
  input  logic              load_inc_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (load_tgt_i) begin
      pc_q <= tgt_i;
    end else if (load_inc_i) begin
      pc_q <= pc_q + ADDR_W'(INSTR_BYTES);
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: PC, single-outstanding imem handshake, one-entry buffer.
// Optional IF_PERF_COUNTERS_EN adds stall/drop performance counters.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INSTR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
`ifdef IF_PERF_COUNTERS_EN
  output logic [31:0]        perf_stall_cycles,
  output logic [15:0]        perf_dropped,
`endif
  output logic [ADDR_W-1:0]  pc_out,
  output logic [INSTR_W-1:0] instruction_out,
  output logic               valid_out
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
  logic [ADDR_W-1:0]  pc_out_q, pc_out_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  pc;
  logic               consume;
  logic               accept;
  logic               discard;
  logic               pc_load_inc;

  fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk        (clk),
    .rst        (rst),
    .load_tgt_i (branch_taken),
    .tgt_i      (branch_addr),
    .load_inc_i (pc_load_inc),
    .pc_o       (pc)
  );

  always_comb begin
    consume    = valid_q & ~freeze;
    imem_req   = 1'b0;
    imem_addr  = req_addr_q;
    accept     = 1'b0;
    discard    = 1'b0;
    state_d    = state_q;
    req_addr_d = req_addr_q;
    pc_out_d   = pc_out_q;
    instr_d    = instr_q;
    valid_d    = valid_q & ~consume;
    unique case (state_q)
      FS_IDLE: begin
        imem_addr = pc;
        imem_req  = ~rst & ~branch_taken & (~valid_q | ~freeze);
        if (imem_req) begin
          req_addr_d = pc;
          if (imem_ready) accept = 1'b1;
          else state_d = FS_WAIT;
        end
      end
      FS_WAIT: begin
        imem_req = ~rst;
        if (imem_ready) begin
          accept  = ~branch_taken;
          discard = branch_taken;
          state_d = FS_IDLE;
        end else if (branch_taken) begin
          state_d = FS_DROP;
        end
      end
      FS_DROP: begin
        // Stale address stays on the bus until memory completes it.
        imem_req = ~rst;
        if (imem_ready) begin
          discard = 1'b1;
          if (!branch_taken) state_d = FS_IDLE;
        end
      end
      default: state_d = FS_IDLE;
    endcase
    if (accept) begin
      instr_d  = imem_rdata;
      pc_out_d = imem_addr + ADDR_W'(INSTR_BYTES);
      valid_d  = 1'b1;
    end
    if (branch_taken) valid_d = 1'b0;
    pc_load_inc = accept;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FS_IDLE;
      req_addr_q <= RESET_PC;
      pc_out_q   <= '0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      pc_out_q   <= pc_out_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
    end
  end

  assign pc_out          = pc_out_q;
  assign instruction_out = instr_q;
  assign valid_out       = valid_q;

`ifdef IF_PERF_COUNTERS_EN
  logic [31:0] stall_q;
  logic [15:0] drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      drop_q  <= '0;
    end else begin
      if (!valid_q && stall_q != '1) stall_q <= stall_q + 32'd1;
      if (discard && drop_q != '1) drop_q <= drop_q + 16'd1;
    end
  end

  assign perf_stall_cycles = stall_q;
  assign perf_dropped      = drop_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomised self-checking bench for instruction_fetch_unit.
// Reference model tracks requests/buffer transactionally.
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic        valid_out;
`ifdef IF_PERF_COUNTERS_EN
  logic [31:0] perf_stall_cycles;
  logic [15:0] perf_dropped;
`endif

  instruction_fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .freeze          (freeze),
    .branch_taken    (branch_taken),
    .branch_addr     (branch_addr),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rdata      (imem_rdata),
`ifdef IF_PERF_COUNTERS_EN
    .perf_stall_cycles (perf_stall_cycles),
    .perf_dropped      (perf_dropped),
`endif
    .pc_out          (pc_out),
    .instruction_out (instruction_out),
    .valid_out       (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  // memory environment
  int          lat;
  int          wcnt;
  logic [31:0] dxor;

  // reference model
  bit          m_out;
  bit          m_taint;
  logic [31:0] m_oaddr;
  logic [31:0] m_pc;
  bit          m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pco;
  logic [31:0] m_stall;
  logic [15:0] m_drop;

  // per-cycle observations
  bit          o_req;
  logic [31:0] o_addr;
  bit          e_req;
  logic [31:0] e_addr;

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    freeze = 1'b0;
    branch_taken = 1'b0;
    branch_addr = '0;
    imem_ready = 1'b0;
    imem_rdata = '0;
    @(posedge clk);
    #1;
    m_out = 0;
    m_taint = 0;
    m_oaddr = '0;
    m_pc = RESET_PC_DEF;
    m_valid = 0;
    m_instr = '0;
    m_pco = '0;
    m_stall = '0;
    m_drop = '0;
    wcnt = 0;
  endtask

  task automatic tick(input bit fr, input bit br, input logic [31:0] ba);
    bit rdy;
    bit ld;
    logic [31:0] a;
    @(negedge clk);
    rst = 1'b0;
    freeze = fr;
    branch_taken = br;
    branch_addr = ba;
    imem_ready = 1'b0;
    #1;
    o_req = imem_req;
    o_addr = imem_addr;
    e_req = m_out || (!br && (!m_valid || !fr));
    e_addr = m_out ? m_oaddr : m_pc;
    rdy = o_req && (wcnt >= lat);
    imem_ready = rdy;
    imem_rdata = o_addr ^ dxor;
    wcnt = (o_req && !rdy) ? wcnt + 1 : 0;
    a = e_addr;
    ld = e_req && rdy && !br && !m_taint;
    if (!m_valid && m_stall != '1) m_stall++;
    if (e_req && rdy && (br || m_taint) && m_drop != '1) m_drop++;
    if (br) m_valid = 0;
    else if (ld) begin
      m_valid = 1;
      m_instr = a ^ dxor;
      m_pco = a + 32'd4;
    end else if (!fr) m_valid = 0;
    if (br) m_pc = ba;
    else if (ld) m_pc = a + 32'd4;
    if (e_req && !rdy) begin
      m_taint = (m_out && m_taint) || br;
      m_oaddr = a;
      m_out = 1;
    end else if (e_req && rdy && m_taint && br) begin
      m_out = 1;
      m_taint = 1;
    end else begin
      m_out = 0;
      m_taint = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (valid_out !== 1'b0) begin
      errs++;
      $display("FAIL rst_valid: got %b want 0", valid_out);
    end
    checks++;
    if (pc_out !== 32'h0 || instruction_out !== 32'h0) begin
      errs++;
      $display("FAIL rst_out: got pc=%h ins=%h want 0/0", pc_out, instruction_out);
    end
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== RESET_PC_DEF) begin
      errs++;
      $display("FAIL rst_req: got req=%b addr=%h want 0/%h", imem_req, imem_addr, RESET_PC_DEF);
    end
  endtask

  task automatic test_zero_wait();
    lat = 0;
    dxor = 0;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0);
      checks++;
      if (o_req !== 1'b1 || o_addr !== 32'(4 * i)) begin
        errs++;
        $display("FAIL zw_req[%0d]: got %b/%h want 1/%h", i, o_req, o_addr, 4 * i);
      end
      checks++;
      if (valid_out !== 1'b1 || pc_out !== 32'(4 * i + 4) || instruction_out !== 32'(4 * i)) begin
        errs++;
        $display("FAIL zw_out[%0d]: got v=%b pc=%h ins=%h want 1/%h/%h",
                 i, valid_out, pc_out, instruction_out, 4 * i + 4, 4 * i);
      end
    end
  endtask

  task automatic test_wait_states();
    lat = 3;
    dxor = 0;
    apply_reset();
    for (int i = 1; i <= 12; i++) begin
      tick(0, 0, 0);
      checks++;
      if (valid_out !== ((i % 4) == 0)) begin
        errs++;
        $display("FAIL ws_valid[%0d]: got %b want %b", i, valid_out, (i % 4) == 0);
      end
      if (i > 8) begin
        checks++;
        if (o_req !== 1'b1 || o_addr !== 32'h8) begin
          errs++;
          $display("FAIL ws_hold[%0d]: got %b/%h want 1/00000008", i, o_req, o_addr);
        end
      end
    end
    checks++;
    if (pc_out !== 32'hC || instruction_out !== 32'h8) begin
      errs++;
      $display("FAIL ws_out: got %h/%h want 0000000c/00000008", pc_out, instruction_out);
    end
  endtask

  task automatic test_freeze();
    lat = 0;
    dxor = 0;
    apply_reset();
    tick(0, 0, 0);
    tick(0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick(1, 0, 0);
      checks++;
      if (o_req !== 1'b0) begin
        errs++;
        $display("FAIL fz_req[%0d]: got %b want 0", i, o_req);
      end
      checks++;
      if (valid_out !== 1'b1 || pc_out !== 32'h8 || instruction_out !== 32'h4) begin
        errs++;
        $display("FAIL fz_hold[%0d]: got %b/%h/%h want 1/8/4", i, valid_out, pc_out, instruction_out);
      end
    end
    tick(0, 0, 0);
    checks++;
    if (valid_out !== 1'b1 || pc_out !== 32'hC || instruction_out !== 32'h8) begin
      errs++;
      $display("FAIL fz_resume: got %b/%h/%h want 1/c/8", valid_out, pc_out, instruction_out);
    end
  endtask

  task automatic test_branch_wait();
    bit seen;
    lat = 0;
    dxor = 0;
    apply_reset();
    repeat (4) tick(0, 0, 0);
    lat = 3;
    tick(0, 0, 0);
    tick(0, 1, 32'h100);
    checks++;
    if (o_req !== 1'b1 || o_addr !== 32'h10) begin
      errs++;
      $display("FAIL bw_wait: got %b/%h want 1/00000010", o_req, o_addr);
    end
    for (int i = 0; i < 6 && m_out; i++) begin
      tick(0, 0, 0);
      checks++;
      if (o_addr !== 32'h10 || valid_out !== 1'b0) begin
        errs++;
        $display("FAIL bw_drop[%0d]: got addr=%h v=%b want 00000010/0", i, o_addr, valid_out);
      end
    end
    tick(0, 0, 0);
    checks++;
    if (o_req !== 1'b1 || o_addr !== 32'h100) begin
      errs++;
      $display("FAIL bw_target: got %b/%h want 1/00000100", o_req, o_addr);
    end
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      tick(0, 0, 0);
      seen = valid_out;
    end
    checks++;
    if (!seen || pc_out !== 32'h104 || instruction_out !== 32'h100) begin
      errs++;
      $display("FAIL bw_load: got v=%b pc=%h ins=%h want 1/104/100", seen, pc_out, instruction_out);
    end
  endtask

  task automatic test_branch_ready();
    lat = 1;
    dxor = 0;
    apply_reset();
    tick(0, 0, 0);
    tick(0, 1, 32'h200);
    checks++;
    if (imem_ready !== 1'b1 || valid_out !== 1'b0) begin
      errs++;
      $display("FAIL br_coinc: got rdy=%b v=%b want 1/0", imem_ready, valid_out);
    end
    tick(0, 0, 0);
    checks++;
    if (o_addr !== 32'h200) begin
      errs++;
      $display("FAIL br_next: got %h want 00000200", o_addr);
    end
    tick(0, 0, 0);
    checks++;
    if (valid_out !== 1'b1 || pc_out !== 32'h204 || instruction_out !== 32'h200) begin
      errs++;
      $display("FAIL br_load: got %b/%h/%h want 1/204/200", valid_out, pc_out, instruction_out);
    end
    tick(1, 1, 32'h300);
    checks++;
    if (o_req !== 1'b0 || valid_out !== 1'b0) begin
      errs++;
      $display("FAIL br_frz: got req=%b v=%b want 0/0", o_req, valid_out);
    end
    tick(0, 0, 0);
    checks++;
    if (o_req !== 1'b1 || o_addr !== 32'h300) begin
      errs++;
      $display("FAIL br_frz_next: got %b/%h want 1/00000300", o_req, o_addr);
    end
    tick(0, 0, 0);
    checks++;
    if (valid_out !== 1'b1 || pc_out !== 32'h304) begin
      errs++;
      $display("FAIL br_frz_load: got %b/%h want 1/304", valid_out, pc_out);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [4];
    exp_pc[0] = 32'hFFFF_FFFC;
    exp_pc[1] = 32'h0000_0000;
    exp_pc[2] = 32'h0000_0004;
    exp_pc[3] = 32'h0000_0106;
    lat = 0;
    dxor = 0;
    apply_reset();
    tick(0, 1, 32'hFFFF_FFF8);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) tick(0, 1, 32'h102);
      tick(0, 0, 0);
      checks++;
      if (valid_out !== 1'b1 || pc_out !== exp_pc[i] || instruction_out !== exp_pc[i] - 32'd4) begin
        errs++;
        $display("FAIL wrap[%0d]: got %b/%h/%h want 1/%h/%h",
                 i, valid_out, pc_out, instruction_out, exp_pc[i], exp_pc[i] - 32'd4);
      end
    end
  endtask

  task automatic test_reset_mid();
    lat = 0;
    dxor = 0;
    apply_reset();
    repeat (3) tick(0, 0, 0);
    lat = 3;
    tick(0, 0, 0);
    tick(0, 0, 0);
    apply_reset();
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== RESET_PC_DEF) begin
      errs++;
      $display("FAIL rm_req: got %b/%h want 0/%h", imem_req, imem_addr, RESET_PC_DEF);
    end
    checks++;
    if (valid_out !== 1'b0 || pc_out !== 32'h0 || instruction_out !== 32'h0) begin
      errs++;
      $display("FAIL rm_out: got %b/%h/%h want 0/0/0", valid_out, pc_out, instruction_out);
    end
`ifdef IF_PERF_COUNTERS_EN
    checks++;
    if (perf_stall_cycles !== 32'h0 || perf_dropped !== 16'h0) begin
      errs++;
      $display("FAIL rm_perf: got %h/%h want 0/0", perf_stall_cycles, perf_dropped);
    end
`endif
    tick(0, 0, 0);
    checks++;
    if (o_req !== 1'b1 || o_addr !== RESET_PC_DEF) begin
      errs++;
      $display("FAIL rm_restart: got %b/%h want 1/%h", o_req, o_addr, RESET_PC_DEF);
    end
  endtask

  task automatic test_random();
    bit fr;
    bit br;
    logic [31:0] ba;
    lat = 0;
    dxor = ARM_NOP;
    apply_reset();
    for (int c = 0; c < 800; c++) begin
      if (c % 50 == 0) begin
        lat = $urandom_range(0, 3);
        dxor = $urandom;
      end
      fr = ($urandom_range(0, 3) == 0);
      br = ($urandom_range(0, 9) == 0);
      ba = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFF4 : $urandom;
      tick(fr, br, ba);
      checks++;
      if (o_req !== e_req || (e_req && o_addr !== e_addr)) begin
        errs++;
        $display("FAIL rnd_req[%0d]: got %b/%h want %b/%h", c, o_req, o_addr, e_req, e_addr);
      end
      checks++;
      if (valid_out !== m_valid) begin
        errs++;
        $display("FAIL rnd_valid[%0d]: got %b want %b", c, valid_out, m_valid);
      end
      if (m_valid) begin
        checks++;
        if (pc_out !== m_pco || instruction_out !== m_instr) begin
          errs++;
          $display("FAIL rnd_out[%0d]: got %h/%h want %h/%h", c, pc_out, instruction_out, m_pco, m_instr);
        end
      end
    end
`ifdef IF_PERF_COUNTERS_EN
    checks++;
    if (perf_stall_cycles !== m_stall || perf_dropped !== m_drop) begin
      errs++;
      $display("FAIL rnd_perf: got %h/%h want %h/%h", perf_stall_cycles, perf_dropped, m_stall, m_drop);
    end
`endif
  endtask

  initial begin
    rst = 1'b1;
    freeze = 1'b0;
    branch_taken = 1'b0;
    branch_addr = '0;
    imem_ready = 1'b0;
    imem_rdata = '0;
    lat = 0;
    wcnt = 0;
    dxor = '0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_freeze();
    test_branch_wait();
    test_branch_ready();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
